// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-cycle wide add/subtract sequencer driving a 16-bit CLA
//
// Splits one 16*CHUNKS-bit add or subtract into 16-bit chunks. The chunks go to an
// external combinational 16-bit adder one per cycle, LSB chunk first. The carry
// ripples between chunks through a register.
// The adder has no carry-out, so carry-out is rebuilt from the adder's operand and
// sum MSBs.
//
// Optional build macro: ADD_SEQ_CHAIN_EN
//   When defined, a new request can be accepted on the same edge that the pending
//   result is consumed (DONE -> RUN directly).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_a, in_b          W-bit operands
//   in_cin              carry-in for add, ignored for subtract
//   in_sub              1 = A-B, 0 = A+B+cin
//   cla_a/cla_b/cla_cin adder drive (zero outside RUN)
//   cla_sum             adder sum (combinational, same cycle)
//   out_valid/out_ready result handshake
//   out_sum             W-bit result (modulo 2^W)
//   out_cout            carry-out of MSB chunk (subtract: 1 = no borrow)
//   out_ovf             signed overflow
//   out_zero            out_sum == 0
module add_seq #(
    parameter int CHUNKS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*CHUNKS-1:0] in_a,
    input  logic [16*CHUNKS-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic [15:0]          cla_a,
    output logic [15:0]          cla_b,
    output logic                 cla_cin,
    input  logic [15:0]          cla_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*CHUNKS-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 out_zero
);

    localparam int W  = 16 * CHUNKS;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic            w_run;
    logic            w_accept;
    logic            w_last;
    logic            w_carry;
    logic            w_ovf;
    logic [15:0]     w_a_chunk;
    logic [15:0]     w_b_chunk;
    logic [W-1:0]    w_sum_full;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // w_accept can only be set here in the chained build.
                if (out_ready) begin
                    w_state_nxt = w_accept ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_run     = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  w_run    = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
`ifdef ADD_SEQ_CHAIN_EN
                in_ready  = out_ready;
`else
                in_ready  = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_idx == LAST);

    // Select the active chunk, and build the full sum as it will be after this
    // edge. This lets out_zero include the chunk being written.
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        w_sum_full = r_sum;
        for (int k = 0; k < CHUNKS; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_chunk               = r_a[k*16 +: 16];
                w_b_chunk               = r_b[k*16 +: 16];
                w_sum_full[k*16 +: 16]  = cla_sum;
            end
        end
    end

    assign cla_a   = w_run ? w_a_chunk : 16'd0;
    assign cla_b   = w_run ? w_b_chunk : 16'd0;
    assign cla_cin = w_run & r_carry;

    // The MSB carry is 1 when both operand MSBs are 1. It is also 1 when exactly one
    // operand MSB is 1 and the sum MSB is 0, because a carry into bit 15 then
    // propagated out.
    assign w_carry = (cla_a[15] & cla_b[15]) | ((cla_a[15] ^ cla_b[15]) & ~cla_sum[15]);
    assign w_ovf   = (cla_a[15] == cla_b[15]) && (cla_sum[15] != cla_a[15]);

    // Datapath. Accept and RUN are exclusive because in_ready is 0 in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub ? 1'b1 : in_cin;
            r_idx   <= '0;
        end else if (w_run) begin
            r_sum   <= w_sum_full;
            r_carry <= w_carry;
            if (w_last) begin
                r_cout <= w_carry;
                r_ovf  <= w_ovf;
                r_zero <= (w_sum_full == '0);
            end else begin
                r_idx  <= r_idx + IW'(1);
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;
    assign out_zero = r_zero;

endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - directed self-checking bench for add_seq (CHUNKS=2)
module tb_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic [15:0] cla_a;
    logic [15:0] cla_b;
    logic        cla_cin;
    logic [15:0] cla_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int n_total;
    int n_bad;

    add_seq #(.CHUNKS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_sum   (cla_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    // Stand-in for the external 16-bit carry-lookahead adder
    assign cla_sum = cla_a + cla_b + {15'd0, cla_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge. Afterwards the DUT is in RUN with idx=0.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Called in RUN idx=1: advance to DONE, check the result, then consume it.
    task automatic finish_op(input string tag, input logic [31:0] sum,
                             input logic cout, input logic ovf, input logic zero);
        check({tag, ".valid_run"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".sum"},   out_sum, sum);
        check({tag, ".cout"},  {31'd0, out_cout}, {31'd0, cout});
        check({tag, ".ovf"},   {31'd0, out_ovf},  {31'd0, ovf});
        check({tag, ".zero"},  {31'd0, out_zero}, {31'd0, zero});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst.out_sum",   out_sum, 32'd0);
        check("rst.flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
        check("rst.cla",       {15'd0, cla_cin, cla_a}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Add with carry between chunks
        start(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        check("add1.in_ready_run", {31'd0, in_ready}, 32'd0);
        check("add1.cla0", {15'd0, cla_cin, cla_a}, {15'd0, 1'b0, 16'hFFFF});
        check("add1.cla_b0", {16'd0, cla_b}, 32'h0001);
        step();
        check("add1.cla_cin1", {31'd0, cla_cin}, 32'd1);
        check("add1.cla1", {cla_a, cla_b}, 32'd0);
        finish_op("add1", 32'h00010000, 1'b0, 1'b0, 1'b0);

        // Full wrap to zero
        start(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        step();
        finish_op("wrap", 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Signed overflow on add
        start(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        step();
        finish_op("ovf_add", 32'h80000000, 1'b0, 1'b1, 1'b0);

        // Signed overflow on subtract (cin ignored)
        start(32'h80000000, 32'h00000001, 1'b0, 1'b1);
        step();
        finish_op("ovf_sub", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Subtract with borrow
        start(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        check("sub.cla_b0",  {16'd0, cla_b}, 32'hFFF8);
        check("sub.cla_cin0", {31'd0, cla_cin}, 32'd1);
        step();
        finish_op("sub", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure in DONE
        start(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_a     = 32'hDEAD0000;
            in_b     = 32'h0000BEEF;
            check("bp.valid", {31'd0, out_valid}, 32'd1);
            check("bp.sum",   out_sum, 32'h2345678A);
            check("bp.flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        in_a      = 32'h00000010;
        in_b      = 32'h00000020;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
`ifdef ADD_SEQ_CHAIN_EN
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("chain.valid", {31'd0, out_valid}, 32'd0);
        check("chain.run_cla", {cla_a, cla_b}, 32'h00100020);
        step();
        finish_op("chain", 32'h00000030, 1'b0, 1'b0, 1'b0);
`else
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp.release_valid", {31'd0, out_valid}, 32'd0);
        check("bp.release_ready", {31'd0, in_ready}, 32'd1);
        check("bp.release_cla",   {cla_a, cla_b}, 32'd0);
        step();
        check("bp.no_capture", {31'd0, in_ready}, 32'd1);
`endif

        // Reset during RUN idx=1
        start(32'h00010001, 32'h00020002, 1'b0, 1'b0);
        step();
        check("rmid.cla_pre", {cla_a, cla_b}, 32'h00010002);
        #1;
        rst_n = 1'b0;
        #1;
        check("rmid.out_valid", {31'd0, out_valid}, 32'd0);
        check("rmid.in_ready",  {31'd0, in_ready}, 32'd1);
        check("rmid.cla",       {cla_a, cla_b}, 32'd0);
        check("rmid.cla_cin",   {31'd0, cla_cin}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("rmid.no_result", {31'd0, out_valid}, 32'd0);
        start(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        step();
        finish_op("after_rst", 32'h00000003, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
